// File: rtl/axi4l_pkg.sv
// AXI4-Lite shared types and response codes.
package axi4l_pkg;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  strb_t;
  typedef logic [1:0]  resp_t;

  localparam resp_t OKAY   = 2'b00;
  localparam resp_t SLVERR = 2'b10;
endpackage

// File: rtl/axi4l_if.sv
// AXI4-Lite bundle with 32-bit data; clock and active-low reset travel with the bus.
interface axi4l_if (
  input logic aclk,
  input logic aresetn
);
  import axi4l_pkg::*;

  addr_t awaddr;
  logic  awvalid;
  logic  awready;
  data_t wdata;
  strb_t wstrb;
  logic  wvalid;
  logic  wready;
  resp_t bresp;
  logic  bvalid;
  logic  bready;
  addr_t araddr;
  logic  arvalid;
  logic  arready;
  data_t rdata;
  resp_t rresp;
  logic  rvalid;
  logic  rready;

  modport slave (
    input  aclk, aresetn,
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

  modport master (
    input  aclk, aresetn,
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );
endinterface

// File: rtl/axi4l_pwm_led.sv
// AXI4-Lite N-channel PWM LED driver; B and R respond one cycle after the beat completes.
// AW/W are latched independently and refused while B is pending; AR is refused while R is pending.
module axi4l_pwm_led
  import axi4l_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int PW = 16
) (
  axi4l_if.slave       axi,
  output logic [N-1:0] led
);
  localparam int NREG = 4 + N;

  typedef struct packed {
    data_t data;
    strb_t strb;
  } wbeat_t;

  logic clk, rst_n;
  assign clk   = axi.aclk;
  assign rst_n = axi.aresetn;

  logic          en, inv, wrap;
  logic [PW-1:0] presc, pc;
  logic [W-1:0]  cnt;
  logic [W:0]    duty [N];
  logic [W:0]    shadow [N];

  logic          aw_held, w_held, bvalid, rvalid;
  logic [9:0]    aw_idx;
  wbeat_t        w_beat;
  resp_t         bresp, rresp;
  data_t         rdata;

  assign axi.awready = !aw_held && !bvalid;
  assign axi.wready  = !w_held && !bvalid;
  assign axi.arready = !rvalid;
  assign axi.bvalid  = bvalid;
  assign axi.bresp   = bresp;
  assign axi.rvalid  = rvalid;
  assign axi.rresp   = rresp;
  assign axi.rdata   = rdata;

  logic       aw_av, w_av, do_wr, wr_hit, ar_hit, ar_fire;
  logic [9:0] wr_idx, ar_idx;
  wbeat_t     wr_beat;
  data_t      wr_old, wr_new, ar_word;
  data_t      regmap [NREG];

  // A beat is available either from its holding register or straight off the bus this cycle.
  assign aw_av   = aw_held || (axi.awvalid && axi.awready);
  assign w_av    = w_held || (axi.wvalid && axi.wready);
  assign do_wr   = aw_av && w_av;
  assign wr_idx  = aw_held ? aw_idx : axi.awaddr[11:2];
  assign wr_beat = w_held ? w_beat : {axi.wdata, axi.wstrb};
  assign ar_idx  = axi.araddr[11:2];
  assign ar_fire = axi.arvalid && axi.arready;
  assign wr_hit  = (wr_idx < 10'(NREG)) && (wr_idx != 10'd3);
  assign ar_hit  = (ar_idx < 10'(NREG)) && (ar_idx != 10'd3);

  always_comb begin
    for (int k = 0; k < NREG; k++) regmap[k] = '0;
    regmap[0][0]      = en;
    regmap[0][1]      = inv;
    regmap[1][PW-1:0] = presc;
    regmap[2][0]      = wrap;
    for (int i = 0; i < N; i++) regmap[4+i][W:0] = duty[i];
  end

  always_comb begin
    ar_word = '0;
    wr_old  = '0;
    for (int k = 0; k < NREG; k++) begin
      if (ar_idx == 10'(k)) ar_word = regmap[k];
      if (wr_idx == 10'(k)) wr_old = regmap[k];
    end
    wr_new = wr_old;
    for (int b = 0; b < 4; b++)
      if (wr_beat.strb[b]) wr_new[8*b +: 8] = wr_beat.data[8*b +: 8];
  end

  logic unused_bits;
  assign unused_bits = ^{axi.awaddr[31:12], axi.awaddr[1:0],
                         axi.araddr[31:12], axi.araddr[1:0], wr_new};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_idx  <= '0;
      w_beat  <= '0;
      bvalid  <= 1'b0;
      bresp   <= OKAY;
      rvalid  <= 1'b0;
      rresp   <= OKAY;
      rdata   <= '0;
    end else begin
      if (do_wr) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= wr_hit ? OKAY : SLVERR;
      end else begin
        if (axi.awvalid && axi.awready) begin
          aw_held <= 1'b1;
          aw_idx  <= axi.awaddr[11:2];
        end
        if (axi.wvalid && axi.wready) begin
          w_held <= 1'b1;
          w_beat <= {axi.wdata, axi.wstrb};
        end
        if (bvalid && axi.bready) bvalid <= 1'b0;
      end

      if (ar_fire) begin
        rvalid <= 1'b1;
        rdata  <= ar_word;
        rresp  <= ar_hit ? OKAY : SLVERR;
      end else if (rvalid && axi.rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  logic tick, wrap_ev, wrap_clr;
  assign tick     = (pc == presc);
  assign wrap_ev  = en && tick && (cnt == '1);
  assign wrap_clr = do_wr && (wr_idx == 10'd2) && wr_beat.strb[0] && wr_beat.data[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en    <= 1'b0;
      inv   <= 1'b0;
      presc <= '0;
      wrap  <= 1'b0;
      for (int i = 0; i < N; i++) duty[i] <= '0;
    end else begin
      if (do_wr && wr_idx == 10'd0) begin
        en  <= wr_new[0];
        inv <= wr_new[1];
      end
      if (do_wr && wr_idx == 10'd1) presc <= wr_new[PW-1:0];
      for (int i = 0; i < N; i++)
        if (do_wr && wr_idx == 10'(4 + i)) duty[i] <= wr_new[W:0];
      // A wrap in the same cycle as the clear keeps the flag set.
      if (wrap_ev) wrap <= 1'b1;
      else if (wrap_clr) wrap <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= '0;
      cnt <= '0;
      led <= '0;
      for (int i = 0; i < N; i++) shadow[i] <= '0;
    end else begin
      if (!en) begin
        pc  <= '0;
        cnt <= '0;
      end else begin
        // pc above a freshly lowered P runs on to its natural wrap before matching again.
        pc <= tick ? '0 : pc + 1'b1;
        if (tick) cnt <= cnt + 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (!en || wrap_ev) shadow[i] <= duty[i];
        led[i] <= en ? (({1'b0, cnt} < shadow[i]) ^ inv) : inv;
      end
    end
  end
endmodule

// File: tb/tb_axi4l_pwm_led.sv
// Bench for axi4l_pwm_led: bus responses go through an expected/observed queue pair.
module tb_axi4l_pwm_led;
  import axi4l_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int PW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] led;

  always #5 clk = ~clk;

  axi4l_if axi (.aclk(clk), .aresetn(rst_n));

  axi4l_pwm_led #(.N(N), .W(W), .PW(PW)) dut (
    .axi (axi),
    .led (led)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } txn_t;

  txn_t  exp_q[$];
  txn_t  obs_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail = 0;

  // High-pulse widths of led[0], measured in clocks.
  int   pw_q[$];
  int   run = 0;
  logic prev0 = 1'b0;
  always @(negedge clk) begin
    if (led[0]) run = prev0 ? run + 1 : 1;
    else if (prev0) pw_q.push_back(run);
    prev0 = led[0];
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic rd(input string name, input logic [31:0] addr,
                    input logic [31:0] edata, input logic [1:0] eresp);
    txn_t e, o;
    int t;
    e.data = edata; e.resp = eresp;
    exp_q.push_back(e); name_q.push_back(name);
    o.data = 'x; o.resp = 'x;
    axi.araddr = addr; axi.arvalid = 1'b1; axi.rready = 1'b1;
    t = 0;
    while (!axi.arready && t < 20) begin @(negedge clk); t++; end
    @(negedge clk);
    axi.arvalid = 1'b0;
    t = 0;
    while (!axi.rvalid && t < 20) begin @(negedge clk); t++; end
    if (axi.rvalid) begin o.data = axi.rdata; o.resp = axi.rresp; end
    @(negedge clk);
    axi.rready = 1'b0;
    obs_q.push_back(o);
  endtask

  task automatic wr(input string name, input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, input logic [1:0] eresp,
                    input int aw_at, input int w_at, input int bhold,
                    output int held, output int stall);
    txn_t e, o;
    bit aw_done, w_done, aw_f, w_f;
    int cyc;
    e.data = '0; e.resp = eresp;
    exp_q.push_back(e); name_q.push_back(name);
    o.data = 'x; o.resp = 'x;
    held = 0; stall = 0; aw_done = 0; w_done = 0; cyc = 0;
    axi.awaddr = addr; axi.wdata = data; axi.wstrb = strb;
    while (!(aw_done && w_done) && cyc < 40) begin
      axi.awvalid = !aw_done && (cyc >= aw_at);
      axi.wvalid  = !w_done && (cyc >= w_at);
      if ((aw_done && axi.awready) || (w_done && axi.wready)) stall++;
      aw_f = axi.awvalid && axi.awready;
      w_f  = axi.wvalid && axi.wready;
      @(negedge clk);
      aw_done = aw_done | aw_f;
      w_done  = w_done | w_f;
      cyc++;
    end
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    for (int i = 0; i < bhold; i++) begin
      if (axi.bvalid && !axi.awready && !axi.wready) held++;
      @(negedge clk);
    end
    axi.bready = 1'b1;
    cyc = 0;
    while (!axi.bvalid && cyc < 20) begin @(negedge clk); cyc++; end
    if (axi.bvalid) begin o.data = '0; o.resp = axi.bresp; end
    @(negedge clk);
    axi.bready = 1'b0;
    obs_q.push_back(o);
  endtask

  task automatic wreg(input string name, input logic [31:0] addr, input logic [31:0] data);
    int h, s;
    wr(name, addr, data, 4'hF, OKAY, 0, 0, 0, h, s);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (led !== 4'b0) begin n_fail++; $display("FAIL reset_led: got %b want 0000", led); end
    n_checks++;
    if ({axi.awready, axi.wready, axi.arready} !== 3'b111) begin
      n_fail++; $display("FAIL reset_ready: got %b want 111", {axi.awready, axi.wready, axi.arready});
    end
    n_checks++;
    if ({axi.bvalid, axi.rvalid} !== 2'b00) begin
      n_fail++; $display("FAIL reset_valid: got %b want 00", {axi.bvalid, axi.rvalid});
    end
    rst_n = 1'b1;
    @(negedge clk);
    rd("rst_ctrl", 32'h000, 32'h0, OKAY);
    rd("rst_presc", 32'h004, 32'h0, OKAY);
    rd("rst_status", 32'h008, 32'h0, OKAY);
    for (int i = 0; i < N; i++) rd("rst_duty", 32'h010 + 4 * i, 32'h0, OKAY);
    while (exp_q.size() > 0) begin
      txn_t e, o; string nm;
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL %s: got data=%h resp=%b want data=%h resp=%b", nm, o.data, o.resp, e.data, e.resp); end
    end
  endtask

  task automatic test_pwm();
    int hi [N];
    int exp_hi [N] = '{64, 256, 0, 128};
    wreg("pwm_wr_duty0", 32'h010, 32'h40);
    wreg("pwm_wr_duty1", 32'h014, 32'h100);
    wreg("pwm_wr_duty2", 32'h018, 32'h0);
    wreg("pwm_wr_duty3", 32'h01C, 32'h80);
    wreg("pwm_wr_presc", 32'h004, 32'h0);
    wreg("pwm_wr_ctrl", 32'h000, 32'h1);
    rd("pwm_status_early", 32'h008, 32'h0, OKAY);
    repeat (4) @(negedge clk);
    for (int i = 0; i < N; i++) hi[i] = 0;
    repeat (256) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (led[i]) hi[i]++;
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (hi[i] !== exp_hi[i]) begin n_fail++; $display("FAIL pwm_high_count[%0d]: got %0d want %0d", i, hi[i], exp_hi[i]); end
    end
    rd("pwm_status_wrap", 32'h008, 32'h1, OKAY);
    while (exp_q.size() > 0) begin
      txn_t e, o; string nm;
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL %s: got data=%h resp=%b want data=%h resp=%b", nm, o.data, o.resp, e.data, e.resp); end
    end
  endtask

  task automatic test_back_to_back();
    int held, stall;
    wr("hs_aw_first", 32'h01C, 32'h11, 4'hF, OKAY, 0, 3, 0, held, stall);
    n_checks++;
    if (stall !== 0) begin n_fail++; $display("FAIL hs_aw_first_stall: got %0d want 0", stall); end
    rd("hs_aw_first_rd", 32'h01C, 32'h11, OKAY);
    wr("hs_w_first", 32'h01C, 32'h22, 4'hF, OKAY, 3, 0, 0, held, stall);
    n_checks++;
    if (stall !== 0) begin n_fail++; $display("FAIL hs_w_first_stall: got %0d want 0", stall); end
    rd("hs_w_first_rd", 32'h01C, 32'h22, OKAY);
    wr("hs_same_cycle", 32'h01C, 32'hFFFF_FFFF, 4'hF, OKAY, 0, 0, 5, held, stall);
    n_checks++;
    if (held !== 5) begin n_fail++; $display("FAIL hs_bvalid_held: got %0d cycles want 5", held); end
    rd("hs_duty_width", 32'h01C, 32'h1FF, OKAY);
    wreg("hs_restore", 32'h01C, 32'h80);
    while (exp_q.size() > 0) begin
      txn_t e, o; string nm;
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL %s: got data=%h resp=%b want data=%h resp=%b", nm, o.data, o.resp, e.data, e.resp); end
    end
  endtask

  task automatic test_strobe_err();
    int h, s;
    wreg("se_disable", 32'h000, 32'h0);
    wr("se_ctrl_nostrb", 32'h000, 32'h3, 4'h0, OKAY, 0, 0, 0, h, s);
    rd("se_ctrl_rd", 32'h000, 32'h0, OKAY);
    wr("se_presc_lane0", 32'h004, 32'hFFFF_FFFF, 4'h1, OKAY, 0, 0, 0, h, s);
    rd("se_presc_rd0", 32'h004, 32'hFF, OKAY);
    wr("se_presc_lane2", 32'h004, 32'hFFFF_FFFF, 4'h4, OKAY, 0, 0, 0, h, s);
    rd("se_presc_rd2", 32'h004, 32'hFF, OKAY);
    wr("se_presc_lane1", 32'h004, 32'h0000_1200, 4'h2, OKAY, 0, 0, 0, h, s);
    rd("se_presc_rd1", 32'h004, 32'h12FF, OKAY);
    rd("se_alias_hi", 32'h1004, 32'h12FF, OKAY);
    rd("se_alias_lo", 32'h007, 32'h12FF, OKAY);
    rd("se_rd_800", 32'h800, 32'h0, SLVERR);
    rd("se_rd_00c", 32'h00C, 32'h0, SLVERR);
    wr("se_wr_020", 32'h020, 32'hFF, 4'hF, SLVERR, 0, 0, 0, h, s);
    rd("se_rd_020", 32'h020, 32'h0, SLVERR);
    rd("se_duty0_kept", 32'h010, 32'h40, OKAY);
    rd("se_duty3_kept", 32'h01C, 32'h80, OKAY);
    rd("se_status_sticky", 32'h008, 32'h1, OKAY);
    wreg("se_w1c", 32'h008, 32'h1);
    rd("se_status_clr", 32'h008, 32'h0, OKAY);
    wreg("se_presc_zero", 32'h004, 32'h0);
    while (exp_q.size() > 0) begin
      txn_t e, o; string nm;
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL %s: got data=%h resp=%b want data=%h resp=%b", nm, o.data, o.resp, e.data, e.resp); end
    end
  endtask

  task automatic test_duty_inv();
    int t;
    int hi [N];
    int exp_hi [N] = '{64, 0, 256, 128};
    logic p;
    wreg("di_enable", 32'h000, 32'h1);
    t = 0; p = led[0];
    while (t < 400 && !(led[0] && !p)) begin p = led[0]; @(negedge clk); t++; end
    pw_q.delete();
    wreg("di_duty0", 32'h010, 32'hC0);
    t = 0;
    while (pw_q.size() < 2 && t < 800) begin @(negedge clk); t++; end
    n_checks++;
    if (pw_q.size() < 2) begin
      n_fail++; $display("FAIL di_pulses: got %0d pulses want 2", pw_q.size());
    end else begin
      if (pw_q[0] !== 64) begin n_fail++; $display("FAIL di_old_width: got %0d want 64", pw_q[0]); end
      n_checks++;
      if (pw_q[1] !== 192) begin n_fail++; $display("FAIL di_new_width: got %0d want 192", pw_q[1]); end
    end
    wreg("di_inv", 32'h000, 32'h3);
    repeat (4) @(negedge clk);
    for (int i = 0; i < N; i++) hi[i] = 0;
    repeat (256) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (led[i]) hi[i]++;
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (hi[i] !== exp_hi[i]) begin n_fail++; $display("FAIL inv_high_count[%0d]: got %0d want %0d", i, hi[i], exp_hi[i]); end
    end
    wreg("di_dis_inv", 32'h000, 32'h2);
    repeat (3) @(negedge clk);
    n_checks++;
    if (led !== 4'hF) begin n_fail++; $display("FAIL di_disabled_inv: got %b want 1111", led); end
    wreg("di_dis", 32'h000, 32'h0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (led !== 4'h0) begin n_fail++; $display("FAIL di_disabled: got %b want 0000", led); end
    while (exp_q.size() > 0) begin
      txn_t e, o; string nm;
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL %s: got data=%h resp=%b want data=%h resp=%b", nm, o.data, o.resp, e.data, e.resp); end
    end
  endtask

  task automatic test_reset_mid();
    int h, s;
    wreg("rm_enable", 32'h000, 32'h1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (led[1] !== 1'b1) begin n_fail++; $display("FAIL rm_led1_on: got %b want 1", led[1]); end
    axi.awaddr = 32'h018; axi.wdata = 32'h55; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.bready = 1'b0;
    @(negedge clk);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    n_checks++;
    if ({axi.bvalid, axi.awready, axi.wready} !== 3'b100) begin
      n_fail++; $display("FAIL rm_b_pending: got %b want 100", {axi.bvalid, axi.awready, axi.wready});
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({axi.bvalid, led} !== 5'b0) begin n_fail++; $display("FAIL rm_async_clear: got %b want 00000", {axi.bvalid, led}); end
    n_checks++;
    if ({axi.awready, axi.wready, axi.arready} !== 3'b111) begin
      n_fail++; $display("FAIL rm_ready_restore: got %b want 111", {axi.awready, axi.wready, axi.arready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    axi.awaddr = 32'h010; axi.awvalid = 1'b1;
    @(negedge clk);
    axi.awvalid = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wr("rm_wr_duty3", 32'h01C, 32'h77, 4'hF, OKAY, 0, 0, 0, h, s);
    rd("rm_duty0", 32'h010, 32'h0, OKAY);
    rd("rm_duty3", 32'h01C, 32'h77, OKAY);
    rd("rm_duty2", 32'h018, 32'h0, OKAY);
    rd("rm_ctrl", 32'h000, 32'h0, OKAY);
    rd("rm_presc", 32'h004, 32'h0, OKAY);
    rd("rm_status", 32'h008, 32'h0, OKAY);
    while (exp_q.size() > 0) begin
      txn_t e, o; string nm;
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL %s: got data=%h resp=%b want data=%h resp=%b", nm, o.data, o.resp, e.data, e.resp); end
    end
  endtask

  initial begin
    axi.awaddr = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
    axi.bready = 1'b0;
    axi.araddr = '0; axi.arvalid = 1'b0;
    axi.rready = 1'b0;
    test_reset();
    test_pwm();
    test_back_to_back();
    test_strobe_err();
    test_duty_inv();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
